fetch_queue: RTL

Instruction fetch queue between the PC register / instruction memory (fetch) and the decode stage of the pipelined RISC-V core. It buffers up to DEPTH fetched {pc, instr} pairs with valid/ready handshakes on both sides, so fetch can run ahead of a stalled decode. It drives `stall_f`, which gates the enable of the enabled PC register. It discards all buffered entries on a branch/jump redirect (`flush`).

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 82 ++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the instruction fetch queue
interface fetch_queue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;

    // Fetch/decode side: presents pairs and consumes the head
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    // Queue side
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular {pc, instr} buffer between fetch and decode with redirect flush
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    fetch_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       stall_f
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h00000013);

    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic             full_n;
    logic             not_empty;
    logic             push;
    logic             pop;

    // Handshake status is a pure function of the occupancy register
    always_comb begin
        full_n    = (count_q < CW'(DEPTH));
        not_empty = (count_q != '0);
        push      = bus.in_valid & full_n;
        pop       = not_empty & bus.out_ready;
    end

    assign bus.in_ready  = full_n;
    assign bus.out_valid = not_empty;
    assign stall_f       = ~full_n;
    assign count         = count_q;

    // Head entry is masked to zero PC / NOP so decode never sees stale storage
    always_comb begin
        bus.out_pc    = '0;
        bus.out_instr = NOP_INSTR;
        if (not_empty) begin
            bus.out_pc    = mem_pc[head];
            bus.out_instr = mem_instr[head];
        end
    end

    // Storage has no reset; a flush-cycle push is dropped so it cannot resurface
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc[tail]    <= bus.in_pc;
            mem_instr[tail] <= bus.in_instr;
        end
    end

    // Pointers and occupancy; flush overrides any push/pop in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
